// File: rtl/pmem_responder_pkg.sv
// Shared LC-3b memory types and pmem line geometry.
// Imported by the pmem responder, its line array and its bus interface.
package pmem_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_pmem_line;

    // Byte offset bits within one 16-byte line.
    localparam int lc3b_pmem_offset_bits = 4;

    typedef enum logic {
        PMEM_OP_READ  = 1'b0,
        PMEM_OP_WRITE = 1'b1
    } pmem_op_e;

    function automatic int unsigned pmem_line_count(input int unsigned index_bits);
        return 32'd1 << index_bits;
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Line-granular pmem bus between a cache (master) and backing memory (slave).
// The request side is held stable until the single-cycle response pulse.
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    lc3b_word      pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    lc3b_pmem_line pmem_wdata;
    lc3b_pmem_line pmem_rdata;
    logic          pmem_resp;
    logic          pmem_error;

    modport master (
        output pmem_address,
        output pmem_read,
        output pmem_write,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  pmem_error
    );

    modport slave (
        input  pmem_address,
        input  pmem_read,
        input  pmem_write,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output pmem_error
    );

endinterface

// File: rtl/pmem_line_array.sv
// Line storage: synchronous write, enable-gated registered read.
// No reset on storage or read register; the owner masks rdata after reset.
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [INDEX_BITS-1:0] rindex,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] windex,
    input  lc3b_pmem_line         wdata,
    output lc3b_pmem_line         rdata
);

    localparam int LINES = int'(pmem_line_count(INDEX_BITS));

    lc3b_pmem_line lines [LINES];

    // The read register only moves on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            lines[windex] <= wdata;
        end
        if (re) begin
            rdata <= lines[rindex];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for full 128-bit lines.
// One transaction at a time: accept in IDLE, count down in BUSY, pulse in RESP.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int INDEX_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    pmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
    localparam bit         SHORT    = (LATENCY == 1);
    localparam int         IDX_LO   = lc3b_pmem_offset_bits;
    localparam int         IDX_HI   = INDEX_BITS + lc3b_pmem_offset_bits - 1;
    localparam lc3b_word   IDX_MASK = 16'(((1 << INDEX_BITS) - 1) << IDX_LO);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $error("pmem_responder: LATENCY must be within 1..255");
        end
    endgenerate

    state_e                state;
    state_e                state_d;
    logic [7:0]            count;
    logic [7:0]            count_d;
    logic [INDEX_BITS-1:0] cap_index;
    pmem_op_e              cap_op;
    lc3b_pmem_line         cap_wdata;
    logic                  error_q;
    logic                  rdata_valid;

    logic [INDEX_BITS-1:0] req_index;
    pmem_op_e              req_op;
    logic                  req_one;
    logic                  req_both;
    logic                  accept;
    logic                  enter_resp;

    logic [INDEX_BITS-1:0] acc_index;
    pmem_op_e              acc_op;
    lc3b_pmem_line         acc_wdata;
    logic                  arr_re;
    logic                  arr_we;
    lc3b_pmem_line         arr_rdata;

    logic                  unused_addr;

    assign req_index   = bus.pmem_address[IDX_HI:IDX_LO];
    assign req_op      = pmem_op_e'(bus.pmem_write);
    assign req_one     = bus.pmem_read ^ bus.pmem_write;
    assign req_both    = bus.pmem_read & bus.pmem_write;
    assign unused_addr = ^(bus.pmem_address & ~IDX_MASK);

    always_comb begin
        state_d    = state;
        count_d    = count;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_one) begin
                    accept = 1'b1;
                    if (SHORT) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        count_d = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                count_d = count - 8'd1;
                if (count == 8'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A one-cycle latency reaches RESP straight from IDLE, bypassing capture.
    always_comb begin
        acc_index = cap_index;
        acc_op    = cap_op;
        acc_wdata = cap_wdata;
        if (state == IDLE) begin
            acc_index = req_index;
            acc_op    = req_op;
            acc_wdata = bus.pmem_wdata;
        end
    end

    assign arr_we = enter_resp & (acc_op == PMEM_OP_WRITE) & ~reset;
    assign arr_re = enter_resp & (acc_op == PMEM_OP_READ) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 8'd0;
            cap_index   <= '0;
            cap_op      <= PMEM_OP_READ;
            cap_wdata   <= '0;
            error_q     <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            error_q <= (state == IDLE) & req_both;
            if (accept) begin
                cap_index <= req_index;
                cap_op    <= req_op;
                cap_wdata <= bus.pmem_wdata;
            end
            if (arr_re) begin
                rdata_valid <= 1'b1;
            end
        end
    end

    pmem_line_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_lines (
        .clk    (clk),
        .re     (arr_re),
        .rindex (acc_index),
        .we     (arr_we),
        .windex (acc_index),
        .wdata  (acc_wdata),
        .rdata  (arr_rdata)
    );

    assign bus.pmem_resp  = (state == RESP);
    assign bus.pmem_error = error_q;
    // Array read register has no reset; show zero until a read lands.
    assign bus.pmem_rdata = rdata_valid ? arr_rdata : '0;

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Line-granular physical-memory responder on the far end of the cache's pmem interface.
- Accepts one read or write of a full 128-bit line, waits a fixed, parameterised latency, then returns data or commits the write.
- Completes each transaction with a single-cycle pmem_resp pulse.
- Serves as the synthesizable backing store under the 2-way cache and as the reference memory in cache benches.

Parameters:
- LATENCY, 10, cycles from request acceptance to pmem_resp; legal range 1..255.
- INDEX_BITS, 6, log2 of line count; line index = pmem_address[INDEX_BITS+3:4].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pmem_address  input  16  byte address. Bits [3:0] are ignored. Bits above INDEX_BITS+3 are ignored, so lines alias.
- pmem_read  input  1  read request; held high until pmem_resp.
- pmem_write  input  1  write request; held high until pmem_resp.
- pmem_wdata  input  128  write line (lc3b_pmem_line).
- pmem_rdata  output  128  read line; valid only in the pmem_resp cycle of a read.
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_error  output  1  one-cycle pulse; pmem_read and pmem_write were both high in IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0.
  - pmem_resp=0, pmem_error=0, pmem_rdata=0.
  - Line array is not cleared; contents are undefined until written.
  - Reset asserted mid-transaction aborts it: no resp, and a pending write is not committed.
- States: IDLE, BUSY, RESP.
- IDLE:
  - read XOR write high in cycle T: capture line index, op, wdata.
    - LATENCY=1: go to RESP.
    - Otherwise: load counter=LATENCY-1 and go to BUSY.
  - read AND write high: pmem_error=1 next cycle, remain IDLE, no array access.
  - Neither high: stay IDLE.
- BUSY:
  - Decrement counter each cycle.
  - When counter==1, go to RESP.
  - Input changes, including request deassertion, are ignored; the captured transaction always completes.
- Transition into RESP:
  - Read: array line is registered into pmem_rdata.
  - Write: array line is written with the captured wdata.
- RESP: pmem_resp=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency rule: a request first seen in IDLE at cycle T gives pmem_resp high exactly in cycle T+LATENCY.
- pmem_rdata outside RESP:
  - Holds its last value; after reset it is 0.
  - A write transaction does not change pmem_rdata.
- Back-to-back: the IDLE cycle after RESP may accept a new request. Minimum spacing is LATENCY+1 cycles per transaction.
- The requester must drop the request in the cycle after resp. If it is still high, it is treated as a new transaction.
- Write-then-read of the same line returns the written data.
- Aliased addresses (differing only above the index bits) map to the same line.
- Counter width is 8 bits; LATENCY=0 or LATENCY>255 is illegal and flagged by an elaboration-time assertion.

Decomposition:
- lc3b_types (already shared): lc3b_word, lc3b_pmem_line. Add constant lc3b_pmem_offset_bits=4 (byte offset within a line).
- State enum stays local to the module.
- Sub-module pmem_line_array:
  - Ports: clk, read index, write index, write enable, 128-bit wdata; 2^INDEX_BITS lines.
  - Synchronous write.
  - Registered read output with no reset; the responder owns the rdata reset mux.

Test Plan:
- Reset release, then idle 20 cycles -> pmem_resp=0, pmem_error=0, pmem_rdata=0 throughout.
- LATENCY=10: write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x0040 at cycle T -> pmem_resp high only at T+10. Then read 0x0048 -> resp at its T'+10, pmem_rdata equals that line.
- Read and write both high in IDLE -> pmem_error pulses one cycle; no resp; the line at that address is unchanged on a later read.
- Alias check, INDEX_BITS=6: write line A to 0x0010, read 0x0410 -> returns A.
- Mid-transaction abuse:
  - Read of 0x0020 accepted; drop pmem_read and change address at T+3 -> resp still at T+10 with line 0x0020 data.
  - Reset at T+5 of a write -> no resp, and a later read shows the old data.
- LATENCY=1 build: back-to-back write then read of the same line with request dropped after each resp -> resps at T+1 and T+3; read returns the written line.
